// File: rtl/cc_tb_pkg.sv
// cc_tb_pkg: shared defaults, quadrature phase encoding and saturating add for the trackball encoder.
package cc_tb_pkg;
  localparam int ACC_W_DEF = 12;
  localparam int STEP_DIV_DEF = 500;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b11, S3 = 2'b10} phase_e;
  function automatic int sat_add(input int a, input int b, input int lim);
    int t;
    t = a + b;
    return t > lim ? lim : t < -lim ? -lim : t;
  endfunction
endpackage

// File: rtl/tb_axis_quad.sv
// tb_axis_quad: one trackball axis - pending accumulator, step metering and Gray-coded phase FSM.
// Half-period acceleration is compiled in when TB_ACCEL_EN is defined.
module tb_axis_quad import cc_tb_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FAST_THRESH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_tick_i,
  input  logic                    half_tick_i,
  input  logic                    strobe_i,
  input  logic signed [ACC_W:0]   delta_i,
  output logic                    a_o,
  output logic                    b_o,
  output logic                    nz_o
);
  localparam int LIM = 2 ** (ACC_W - 1) - 1;
`ifdef TB_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif
  logic signed [ACC_W-1:0] acc_q, acc_d;
  phase_e ph_q, ph_d;
  logic go, fwd;
  int mag;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ph_q  <= S0;
    end else begin
      acc_q <= acc_d;
      ph_q  <= ph_d;
    end
  end
  // the step uses the pre-update sign; a same-cycle strobe folds into one saturating sum
  always_comb begin
    mag = acc_q < 0 ? -int'(acc_q) : int'(acc_q);
    fwd = !acc_q[ACC_W-1];
    go = (acc_q != '0) && (step_tick_i || (ACCEL && mag >= FAST_THRESH && half_tick_i));
    acc_d = ACC_W'(sat_add(int'(acc_q), (strobe_i ? int'(delta_i) : 0) - (go ? (fwd ? 1 : -1) : 0), LIM));
    nz_o = acc_d != '0;
  end
  always_comb begin
    ph_d = !go ? ph_q : fwd ? phase_e'({ph_q[0], ~ph_q[1]}) : phase_e'({~ph_q[0], ph_q[1]});
  end
  always_comb begin
    {a_o, b_o} = ph_q;
  end
endmodule

// File: rtl/trackball_quad_encoder.sv
// trackball_quad_encoder: mouse deltas to metered H/V quadrature trackball signals.
// Define TB_ACCEL_EN to let large pending counts also step on the half-period tick.
module trackball_quad_encoder import cc_tb_pkg::*; #(
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SENS_SHIFT = 0,
  parameter int FAST_THRESH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mouse_strobe,
  input  logic signed [8:0] mouse_dx,
  input  logic signed [8:0] mouse_dy,
  input  logic              flip,
  output logic              tb_hd,
  output logic              tb_hc,
  output logic              tb_vd,
  output logic              tb_vc,
  output logic              busy
);
  localparam int CW = $clog2(STEP_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic step_tick, half_tick, h_nz, v_nz, busy_q;
  logic signed [ACC_W:0] dh, dv;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= h_nz | v_nz;
    end
  end
  // one extra bit keeps -(-256) << 3 representable before saturation
  always_comb begin
    step_tick = cnt_q == CW'(STEP_DIV - 1);
    half_tick = cnt_q == CW'(STEP_DIV / 2 - 1);
    cnt_d = step_tick ? '0 : cnt_q + 1'b1;
    dh = (flip ? -((ACC_W+1)'(mouse_dx)) : (ACC_W+1)'(mouse_dx)) <<< SENS_SHIFT;
    dv = (flip ? -((ACC_W+1)'(mouse_dy)) : (ACC_W+1)'(mouse_dy)) <<< SENS_SHIFT;
  end
  assign busy = busy_q;
  tb_axis_quad #(.ACC_W(ACC_W), .FAST_THRESH(FAST_THRESH)) u_h (
    .clk(clk), .reset(reset), .step_tick_i(step_tick), .half_tick_i(half_tick),
    .strobe_i(mouse_strobe), .delta_i(dh), .a_o(tb_hd), .b_o(tb_hc), .nz_o(h_nz)
  );
  tb_axis_quad #(.ACC_W(ACC_W), .FAST_THRESH(FAST_THRESH)) u_v (
    .clk(clk), .reset(reset), .step_tick_i(step_tick), .half_tick_i(half_tick),
    .strobe_i(mouse_strobe), .delta_i(dv), .a_o(tb_vd), .b_o(tb_vc), .nz_o(v_nz)
  );
endmodule

// File: tb/tb_trackball_quad_encoder.sv
// tb_trackball_quad_encoder: directed checks of stepping, flip, saturation, reversal and async reset.
module tb_trackball_quad_encoder;
  logic clk = 0, reset = 1, mouse_strobe = 0, flip = 0;
  logic signed [8:0] mouse_dx = 0, mouse_dy = 0;
  logic tb_hd, tb_hc, tb_vd, tb_vc, busy;
  int checks = 0, failures = 0, cyc = 0, max_flips = 0;
  logic [1:0] prev_h = 0, prev_v = 0;

  trackball_quad_encoder dut (
    .clk(clk), .reset(reset), .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx),
    .mouse_dy(mouse_dy), .flip(flip), .tb_hd(tb_hd), .tb_hc(tb_hc),
    .tb_vd(tb_vd), .tb_vc(tb_vc), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if ($countones({tb_hd, tb_hc} ^ prev_h) > max_flips) max_flips = $countones({tb_hd, tb_hc} ^ prev_h);
      if ($countones({tb_vd, tb_vc} ^ prev_v) > max_flips) max_flips = $countones({tb_vd, tb_vc} ^ prev_v);
    end
    prev_h = {tb_hd, tb_hc};
    prev_v = {tb_vd, tb_vc};
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input int dx, input int dy, input bit f);
    mouse_dx = 9'(dx);
    mouse_dy = 9'(dy);
    flip = f;
    mouse_strobe = 1;
    @(negedge clk);
    mouse_strobe = 0;
  endtask

  task automatic wait_h(input string tag, input int exp);
    logic [1:0] p;
    int n;
    p = {tb_hd, tb_hc};
    n = 0;
    while ({tb_hd, tb_hc} == p && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {tb_hd, tb_hc}, exp);
    check({tag, "_tick"}, cyc % 500, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_h", {tb_hd, tb_hc}, 0);
    check("rst_v", {tb_vd, tb_vc}, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", dut.u_h.acc_q, 0);
    reset = 0;
    @(negedge clk);
    strobe(3, 0, 0);
    check("t1_busy", busy, 1);
    wait_h("t1_s1", 1);
    wait_h("t1_s2", 3);
    check("t1_busy_mid", busy, 1);
    wait_h("t1_s3", 2);
    check("t1_busy_end", busy, 0);
    check("t1_v", {tb_vd, tb_vc}, 0);
    do_reset;
    strobe(-2, 0, 0);
    wait_h("t2_b1", 2);
    wait_h("t2_b2", 3);
    strobe(-2, 0, 1);
    wait_h("t2_f1", 2);
    wait_h("t2_f2", 0);
    check("t2_busy", busy, 0);
    for (int i = 0; i < 9; i++) strobe(255, 0, 0);
    check("t3_sat", dut.u_h.acc_q, 2047);
    check("t3_busy", busy, 1);
    wait_h("t3_s1", 1);
    check("t3_dec", dut.u_h.acc_q, 2046);
    #2 reset = 1;
    #1;
    check("t4_h", {tb_hd, tb_hc}, 0);
    check("t4_busy", busy, 0);
    check("t4_acc", dut.u_h.acc_q, 0);
    @(negedge clk);
    reset = 0;
    repeat (1100) @(negedge clk);
    check("t4_idle_h", {tb_hd, tb_hc}, 0);
    check("t4_idle_busy", busy, 0);
    strobe(1, 0, 0);
    while (cyc % 500 != 499) @(negedge clk);
    check("t5_pre_acc", dut.u_h.acc_q, 1);
    strobe(5, 0, 0);
    check("t5_acc", dut.u_h.acc_q, 5);
    check("t5_h", {tb_hd, tb_hc}, 1);
    check("t5_tick", cyc % 500, 0);
    do_reset;
    strobe(4, -1, 0);
    wait_h("t6_f1", 1);
    check("t6_v", {tb_vd, tb_vc}, 2);
    strobe(-6, 0, 0);
    check("t6_acc", dut.u_h.acc_q, -3);
    wait_h("t6_b1", 0);
    wait_h("t6_b2", 2);
    wait_h("t6_b3", 3);
    check("t6_busy", busy, 0);
    check("t6_v_hold", {tb_vd, tb_vc}, 2);
    check("gray_max_bits", max_flips, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
